// File: rtl/multicycle_control_unit_pkg.sv
// rtl/multicycle_control_unit_pkg.sv - opcodes, states, ALU codes and mux selects for the multicycle control unit
package multicycle_control_unit_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BRANCH, S_TRAP
  } state_t;

  // Which kind of ALU operation the FSM wants in the current state
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  // ALU operation codes; the base set fits in 3 bits
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SRL  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/multicycle_alu_decode.sv
// rtl/multicycle_alu_decode.sv - ALU operation select and width legality from funct fields
module multicycle_alu_decode
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  aluop_t               aluop,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 rtype,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 legal
);

  logic [3:0] funct_op;
  logic       wide;
  logic [3:0] code;

  // legal describes the funct fields regardless of aluop so DECODE can trap on it
  always_comb begin
    funct_op = ALU_ADD;
    wide     = 1'b0;
    case (funct3)
      3'b000: funct_op = (rtype && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: begin funct_op = ALU_SLL;  wide = 1'b1; end
      3'b010: funct_op = ALU_SLT;
      3'b011: begin funct_op = ALU_SLTU; wide = 1'b1; end
      3'b100: begin funct_op = ALU_XOR;  wide = 1'b1; end
      3'b101: begin funct_op = funct7b5 ? ALU_SRA : ALU_SRL; wide = 1'b1; end
      3'b110: funct_op = ALU_OR;
      default: funct_op = ALU_AND;
    endcase
    legal = !wide || (ALUCTRL_W >= 4);
    case (aluop)
      ALUOP_ADD: code = ALU_ADD;
      ALUOP_SUB: code = ALU_SUB;
      default:   code = funct_op;
    endcase
    alucontrol = ALUCTRL_W'(code);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV32I control FSM with memory handshake and trap
module multicycle_control_unit
  import multicycle_control_unit_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           Op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 MemReady,
  output logic                 MemReq,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [1:0]           MemSize,
  output logic                 MemUnsigned,
  output logic                 Retire,
  output logic                 Illegal
);

  state_t               state, state_next;
  aluop_t               aluop;
  logic [ALUCTRL_W-1:0] alu_ctrl;
  logic                 alu_legal;
  logic                 ready;
  logic                 f3_ok;
  logic                 taken;

  assign ready = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  multicycle_alu_decode #(.ALUCTRL_W(ALUCTRL_W)) u_alu_decode (
    .aluop      (aluop),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .rtype      (Op == OP_OP),
    .alucontrol (alu_ctrl),
    .legal      (alu_legal)
  );

  // state register; reset always restarts at FETCH, which also clears the trap
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  // funct3 legality per opcode class and branch-condition resolution
  always_comb begin
    f3_ok = 1'b1;
    case (Op)
      OP_LOAD:           f3_ok = !(funct3[1] && funct3[0]) && !(funct3[2] && funct3[1]);
      OP_STORE:          f3_ok = !funct3[2] && !(funct3[1] && funct3[0]);
      OP_BRANCH:         f3_ok = !funct3[1];
      OP_OP, OP_OPIMM:   f3_ok = alu_legal;
      default:           f3_ok = 1'b1;
    endcase
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Lt;
      3'b101:  taken = !Lt;
      default: taken = 1'b0;
    endcase
  end

  // next-state and output decode; reset forces every output low immediately
  always_comb begin
    state_next  = state;
    aluop       = ALUOP_ADD;
    MemReq      = 1'b0;
    MemWrite    = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    ResultSrc   = RES_ALUOUT;
    ALUControl  = '0;
    Retire      = 1'b0;
    Illegal     = 1'b0;
    case (Op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
    if (Op == OP_LOAD || Op == OP_STORE) begin
      MemSize     = funct3[1:0];
      MemUnsigned = funct3[2];
    end else begin
      MemSize     = SIZE_WORD;
      MemUnsigned = 1'b0;
    end

    case (state)
      S_FETCH: begin
        MemReq    = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = ready;
        PCWrite   = ready;
        if (ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        if (!f3_ok) state_next = S_TRAP;
        else begin
          case (Op)
            OP_LOAD, OP_STORE: state_next = S_MEMADR;
            OP_OP:             state_next = S_EXECUTER;
            OP_OPIMM:          state_next = S_EXECUTEI;
            OP_BRANCH:         state_next = S_BRANCH;
            OP_JAL:            state_next = S_JAL;
            default:           state_next = S_TRAP;
          endcase
        end
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (Op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        Retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        Retire   = ready;
        if (ready) state_next = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        aluop      = ALUOP_FUNCT;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_RS2;
        ALUControl = alu_ctrl;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        Retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_BRANCH: begin
        aluop      = ALUOP_SUB;
        ALUSrcA    = SRCA_RS1;
        ALUControl = alu_ctrl;
        PCWrite    = taken;
        Retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        Illegal     = 1'b1;
        ImmSrc      = 2'b00;
        MemSize     = 2'b00;
        MemUnsigned = 1'b0;
        state_next  = S_TRAP;
      end
    endcase

    if (reset) begin
      MemReq      = 1'b0;
      MemWrite    = 1'b0;
      AdrSrc      = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ResultSrc   = 2'b00;
      ImmSrc      = 2'b00;
      ALUControl  = '0;
      MemSize     = 2'b00;
      MemUnsigned = 1'b0;
      Retire      = 1'b0;
      Illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - directed self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7b5, Zero, Lt, MemReady;
  logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, MemSize;
  logic [2:0] ALUControl;
  logic       MemUnsigned, Retire, Illegal;

  int total  = 0;
  int passed = 0;

  multicycle_control_unit #(.ALUCTRL_W(3), .MEM_HANDSHAKE(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .Lt(Lt), .MemReady(MemReady), .MemReq(MemReq), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .MemSize(MemSize), .MemUnsigned(MemUnsigned),
    .Retire(Retire), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one branch from FETCH through BRANCH and back to FETCH
  task automatic run_branch(input string tag, input logic [2:0] f3, input logic z,
                            input logic lt, input logic exp_pc);
    Op = 7'b1100011; funct3 = f3; Zero = z; Lt = lt; MemReady = 1'b1;
    #1;
    tick();
    tick();
    chk({tag, "_pcwrite"}, PCWrite, exp_pc);
    chk({tag, "_retire"}, Retire, 1);
    chk({tag, "_alu_sub"}, ALUControl, 1);
    tick();
  endtask

  initial begin
    reset = 1'b1; Op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    Zero = 1'b0; Lt = 1'b0; MemReady = 1'b0;
    tick();
    tick();
    chk("rst_memreq", MemReq, 0);
    chk("rst_illegal", Illegal, 0);
    chk("rst_memsize", MemSize, 0);
    chk("rst_alusrcb", ALUSrcB, 0);

    // add x3,x1,x2
    reset = 1'b0; Op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; MemReady = 1'b1;
    #1;
    chk("add_f_memreq", MemReq, 1);
    chk("add_f_irwrite", IRWrite, 1);
    chk("add_f_pcwrite", PCWrite, 1);
    chk("add_f_srcb", ALUSrcB, 2);
    chk("add_f_result", ResultSrc, 2);
    tick();
    chk("add_d_srca", ALUSrcA, 1);
    chk("add_d_srcb", ALUSrcB, 1);
    chk("add_d_memreq", MemReq, 0);
    tick();
    chk("add_e_srca", ALUSrcA, 2);
    chk("add_e_srcb", ALUSrcB, 0);
    chk("add_e_alu", ALUControl, 0);
    chk("add_e_regwrite", RegWrite, 0);
    tick();
    chk("add_wb_regwrite", RegWrite, 1);
    chk("add_wb_retire", Retire, 1);
    chk("add_wb_result", ResultSrc, 0);
    tick();
    chk("add_next_retire", Retire, 0);
    chk("add_next_memreq", MemReq, 1);

    // lw with 3 fetch waits and 2 read waits: 10 cycles
    Op = 7'b0000011; funct3 = 3'b010; MemReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_fwait_memreq", MemReq, 1);
      chk("lw_fwait_irwrite", IRWrite, 0);
      chk("lw_fwait_pcwrite", PCWrite, 0);
      tick();
    end
    MemReady = 1'b1;
    #1;
    chk("lw_f_irwrite", IRWrite, 1);
    chk("lw_f_pcwrite", PCWrite, 1);
    tick();
    tick();
    chk("lw_ma_srca", ALUSrcA, 2);
    chk("lw_ma_srcb", ALUSrcB, 1);
    chk("lw_ma_memsize", MemSize, 2);
    chk("lw_ma_memreq", MemReq, 0);
    tick();
    MemReady = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("lw_rwait_memreq", MemReq, 1);
      chk("lw_rwait_adrsrc", AdrSrc, 1);
      chk("lw_rwait_regwrite", RegWrite, 0);
      tick();
    end
    MemReady = 1'b1;
    #1;
    chk("lw_r_memreq", MemReq, 1);
    tick();
    chk("lw_wb_regwrite", RegWrite, 1);
    chk("lw_wb_result", ResultSrc, 1);
    chk("lw_wb_retire", Retire, 1);
    tick();
    chk("lw_next_memreq", MemReq, 1);
    chk("lw_next_retire", Retire, 0);

    // lbu
    Op = 7'b0000011; funct3 = 3'b100;
    #1;
    tick();
    tick();
    tick();
    chk("lbu_memsize", MemSize, 0);
    chk("lbu_unsigned", MemUnsigned, 1);
    chk("lbu_memreq", MemReq, 1);
    chk("lbu_memwrite", MemWrite, 0);
    tick();
    tick();

    // sh with one write wait
    Op = 7'b0100011; funct3 = 3'b001;
    #1;
    tick();
    chk("sh_d_immsrc", ImmSrc, 1);
    chk("sh_d_memwrite", MemWrite, 0);
    tick();
    chk("sh_ma_memwrite", MemWrite, 0);
    tick();
    MemReady = 1'b0;
    #1;
    chk("sh_w_memwrite", MemWrite, 1);
    chk("sh_w_adrsrc", AdrSrc, 1);
    chk("sh_w_memsize", MemSize, 1);
    chk("sh_w_unsigned", MemUnsigned, 0);
    chk("sh_w_retire_wait", Retire, 0);
    MemReady = 1'b1;
    #1;
    chk("sh_w_retire", Retire, 1);
    tick();
    chk("sh_next_memwrite", MemWrite, 0);

    run_branch("beq_z0", 3'b000, 1'b0, 1'b0, 1'b0);
    run_branch("bne_z0", 3'b001, 1'b0, 1'b0, 1'b1);
    run_branch("bge_lt1", 3'b101, 1'b0, 1'b1, 1'b0);

    // sw interrupted by reset during the write wait
    Op = 7'b0100011; funct3 = 3'b010; MemReady = 1'b1;
    #1;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    #1;
    chk("sw_w_memwrite", MemWrite, 1);
    reset = 1'b1; MemReady = 1'b1;
    tick();
    chk("sw_rst_memreq", MemReq, 0);
    chk("sw_rst_memwrite", MemWrite, 0);
    chk("sw_rst_retire", Retire, 0);
    reset = 1'b0;
    #1;
    chk("sw_rst_fetch_memreq", MemReq, 1);
    chk("sw_rst_fetch_adrsrc", AdrSrc, 0);
    chk("sw_rst_fetch_srcb", ALUSrcB, 2);

    // unknown opcode traps and stays trapped
    Op = 7'b1111111;
    #1;
    tick();
    chk("bad_d_illegal", Illegal, 0);
    tick();
    Op = 7'b0110011; funct3 = 3'b000;
    for (int i = 0; i < 20; i++) begin
      chk("bad_trap_illegal", Illegal, 1);
      chk("bad_trap_memreq", MemReq, 0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("bad_rst_illegal", Illegal, 0);
    chk("bad_rst_memreq", MemReq, 1);

    // xor is illegal with a 3-bit ALUControl
    Op = 7'b0110011; funct3 = 3'b100;
    #1;
    tick();
    tick();
    chk("xor_trap_illegal", Illegal, 1);
    tick();
    chk("xor_trap_hold", Illegal, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("xor_rst_illegal", Illegal, 0);

    // sub selected by funct7b5 on R-type
    Op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    #1;
    tick();
    tick();
    chk("sub_e_alu", ALUControl, 1);
    tick();
    chk("sub_wb_regwrite", RegWrite, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Sequential successor to the single-cycle control decoder. It drives a shared-memory, multicycle RV32I datapath through an FSM, one instruction per 3–5+ cycles. It adds a memory request/ready handshake with wait states, branch-condition resolution for beq/bne/blt/bge, and byte/half/word load/store sizing. Illegal encodings trap into a sticky state. It sits between the instruction register and the datapath muxes, register file and memory port.

Parameters:
ALUCTRL_W, 3, width of ALUControl. At 3, only add/sub/and/or/slt are legal. At 4 or more, xor/sll/srl/sra/sltu are also legal.
MEM_HANDSHAKE, 1, selects memory handshake mode. At 1, memory states wait for MemReady. At 0, MemReady is treated as constant 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Op  in  7  instruction[6:0] from IR
funct3  in  3  instruction[14:12]
funct7b5  in  1  instruction[30]
Zero  in  1  ALU result == 0
Lt  in  1  signed rs1 < rs2, from ALU flags
MemReady  in  1  memory completes the current request this cycle
MemReq  out  1  memory access request
MemWrite  out  1  store strobe, valid only with MemReq
AdrSrc  out  1  memory address source: 0 = PC, 1 = ALUOut
IRWrite  out  1  latch the fetched instruction
PCWrite  out  1  PC register enable
RegWrite  out  1  register file write enable
ALUSrcA  out  2  ALU input A: 00 = PC, 01 = OldPC, 10 = rs1
ALUSrcB  out  2  ALU input B: 00 = rs2, 01 = imm, 10 = constant 4
ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
ImmSrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
ALUControl  out  ALUCTRL_W  ALU operation
MemSize  out  2  access size: 00 = byte, 01 = half, 10 = word
MemUnsigned  out  1  zero-extend loaded data (lbu/lhu)
Retire  out  1  one-cycle pulse when an instruction completes
Illegal  out  1  sticky trap flag

Behaviour:
- Reset: synchronous and active-high; state goes to FETCH. While reset is high, all outputs are 0.
- Reset asserted mid-access drops MemReq on the next edge. No partial write-back occurs.
- Unlisted outputs in each state are 0. ImmSrc and MemSize are pure decodes of Op/funct3 in every state.
- Hold rule: every memory state holds all of its outputs unchanged while MemReady=0.
- FETCH:
  - Outputs: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU=add, ResultSrc=10.
  - IRWrite and PCWrite assert only in the cycle MemReady=1. Leave to DECODE on MemReady.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALU=add (branch/jump target into ALUOut).
  - Next state by Op: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BRANCH; 1101111 -> JAL; anything else -> TRAP.
  - Also -> TRAP: branch funct3 outside {000,001,100,101}; load funct3 outside {000,001,010,100,101}; store funct3 outside {000,001,010}; ALU funct3 needing ALUCTRL_W>=4 when ALUCTRL_W=3.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALU=add. Next is MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: MemReq=1, AdrSrc=1, ResultSrc=00. Wait for MemReady, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Next is FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1, ResultSrc=00. Wait for MemReady, then Retire=1 and -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALU from funct3/funct7b5. Next is ALUWB.
  - sub applies when funct7b5=1 on an R-type.
  - sra applies when funct7b5=1 with funct3=101.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALU from funct3. funct7b5 is ignored except for shifts. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Next is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALU=add, ResultSrc=00, PCWrite=1. Next is ALUWB (writes PC+4 to rd).
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALU=sub, ResultSrc=00, Retire=1. Next is FETCH.
  - PCWrite = taken, where beq=Zero, bne=~Zero, blt=Lt, bge=~Lt.
- TRAP: all outputs 0 except Illegal=1. Held until reset.
- ALU encodings:
  - Base: add=0, sub=1, and=2, or=3, slt=5.
  - With ALUCTRL_W>=4: xor=4, sll=6, srl=7, sra=8, sltu=9.
  - Values are zero-extended to ALUCTRL_W.
- MemSize/MemUnsigned: taken from funct3[1:0] and funct3[2] for loads and stores; forced to 10/0 otherwise.

Decomposition:
- Shared package: opcode constants (extending the existing LOAD/STORE set with OP, OP_IMM, BRANCH, JAL), the state enum, ALU operation codes, and the mux-select encodings.
- One combinational sub-module, multicycle_alu_decode: inputs ALUOp class, funct3, funct7b5 and an R-type flag; outputs ALUControl and a legal flag.

Test Plan:
- add x3,x1,x2 with MemReady=1 throughout -> states FETCH,DECODE,EXECUTER,ALUWB. RegWrite=1 in cycle 4, Retire pulses once, ALUControl=0.
- lw, MemReady low for 3 cycles in FETCH and 2 in MEMREAD -> IRWrite/PCWrite pulse only on ready cycles. MemReq held. RegWrite in MEMWB, 10 cycles total.
- lbu then sh -> MemSize=00/MemUnsigned=1, then MemSize=01/MemWrite=1 only in MEMWRITE with AdrSrc=1.
- beq Zero=0, then bne Zero=0, then bge Lt=1 -> PCWrite in BRANCH = 0, 1, 0 respectively.
- Op=1111111, and separately ALUCTRL_W=3 with xor -> TRAP, Illegal=1 sticky over 20 cycles. Reset pulse returns to FETCH with Illegal=0.
- Reset asserted during MEMWRITE wait -> next cycle MemReq=0, MemWrite=0, state FETCH, no Retire.
